// File: rtl/shift_arbiter_pkg.sv
// Shared types and constants for the round-robin shared-shifter arbiter.
package shift_arbiter_pkg;

  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_SHIFT_W = 3;
  localparam int unsigned DEF_NREQ    = 4;
  localparam int unsigned DEF_ID_W    = 2;

  typedef logic [DEF_WIDTH-1:0]   operand_t;
  typedef logic [DEF_SHIFT_W-1:0] shamt_t;
  typedef logic [DEF_ID_W-1:0]    req_id_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/left_shift_core.sv
// Combinational zero-fill left shifter; shifts of WIDTH or more give zero.
module left_shift_core #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SHIFT_W = 3
) (
  input  logic [WIDTH-1:0]   iBits,
  input  logic [SHIFT_W-1:0] shift,
  output logic [WIDTH-1:0]   oBits
);

  assign oBits = (32'(shift) >= WIDTH) ? '0 : (iBits << shift);

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter time-multiplexing one left shifter over NREQ clients,
// with a one-entry registered result and valid/ready handshake.
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned SHIFT_W = DEF_SHIFT_W,
  parameter int unsigned NREQ    = DEF_NREQ,
  parameter int unsigned ID_W    = DEF_ID_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_bits,
  input  logic [NREQ*SHIFT_W-1:0] req_shift,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [WIDTH-1:0]        rsp_bits,
  output logic [ID_W-1:0]         rsp_id
);

  out_state_e        r_state;
  logic [WIDTH-1:0]  r_bits;
  logic [ID_W-1:0]   r_id;
  logic [ID_W-1:0]   r_ptr;

  logic              w_can_accept;
  logic              w_found;
  logic [ID_W-1:0]   w_gid;
  logic              w_fire;
  logic [ID_W-1:0]   w_next_ptr;
  logic [WIDTH-1:0]  w_op;
  logic [SHIFT_W-1:0] w_shamt;
  logic [WIDTH-1:0]  w_shifted;

  // Priority scan starting at r_ptr, wrapping modulo NREQ.
  always_comb begin : scan
    int unsigned idx;
    idx          = 0;
    w_can_accept = !rst && ((r_state == ST_EMPTY) || rsp_ready);
    w_found      = 1'b0;
    w_gid        = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(r_ptr) + k) % NREQ;
      if (!w_found && req_valid[ID_W'(idx)]) begin
        w_found = 1'b1;
        w_gid   = ID_W'(idx);
      end
    end
    w_fire     = w_can_accept && w_found;
    w_next_ptr = ID_W'((32'(w_gid) + 1) % NREQ);
  end

  assign req_ready = w_fire ? (NREQ'(1) << w_gid) : '0;
  assign w_op      = req_bits[32'(w_gid)*WIDTH +: WIDTH];
  assign w_shamt   = req_shift[32'(w_gid)*SHIFT_W +: SHIFT_W];

  left_shift_core #(
    .WIDTH   (WIDTH),
    .SHIFT_W (SHIFT_W)
  ) u_shift (
    .iBits (w_op),
    .shift (w_shamt),
    .oBits (w_shifted)
  );

  // Output register; a grant while draining refills without a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_bits  <= '0;
      r_id    <= '0;
      r_ptr   <= '0;
    end else begin
      if (w_fire) begin
        r_bits <= w_shifted;
        r_id   <= w_gid;
        r_ptr  <= w_next_ptr;
      end
      case (r_state)
        ST_EMPTY: if (w_fire) r_state <= ST_FULL;
        ST_FULL:  if (rsp_ready && !w_fire) r_state <= ST_EMPTY;
        default:  r_state <= ST_EMPTY;
      endcase
    end
  end

  assign rsp_valid = (r_state == ST_FULL);
  assign rsp_bits  = r_bits;
  assign rsp_id    = r_id;

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed scenarios plus randomized
// traffic against an abstract round-robin/arithmetic-shift reference model.
module tb_shift_arbiter;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned SHIFT_W = 3;
  localparam int unsigned NREQ    = 4;
  localparam int unsigned ID_W    = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*WIDTH-1:0]   req_bits;
  logic [NREQ*SHIFT_W-1:0] req_shift;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [WIDTH-1:0]        rsp_bits;
  logic [ID_W-1:0]         rsp_id;

  logic [1:0] v4;
  logic [1:0] rdy4;
  logic [7:0] b4;
  logic [5:0] s4;
  logic       rv4;
  logic       rr4;
  logic [3:0] rb4;
  logic       rid4;

  int checks   = 0;
  int failures = 0;

  int          m_ptr;
  int          m_id;
  logic        m_full;
  int unsigned m_bits;
  int          g_last;
  logic [NREQ-1:0] pend;

  always #5 clk = ~clk;

  shift_arbiter #(
    .WIDTH(WIDTH), .SHIFT_W(SHIFT_W), .NREQ(NREQ), .ID_W(ID_W)
  ) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_bits(req_bits), .req_shift(req_shift),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_bits(rsp_bits), .rsp_id(rsp_id)
  );

  shift_arbiter #(
    .WIDTH(4), .SHIFT_W(3), .NREQ(2), .ID_W(1)
  ) u_dut4 (
    .clk(clk), .rst(rst),
    .req_valid(v4), .req_ready(rdy4),
    .req_bits(b4), .req_shift(s4),
    .rsp_valid(rv4), .rsp_ready(rr4),
    .rsp_bits(rb4), .rsp_id(rid4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int model_grant(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < int'(NREQ); k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic int unsigned model_shift(input int unsigned b, input int unsigned s);
    if (s >= WIDTH) return 0;
    return (b * (32'd1 << s)) % (32'd1 << WIDTH);
  endfunction

  task automatic set_req(input int i, input int unsigned b, input int unsigned s);
    req_bits[i*WIDTH +: WIDTH]      = WIDTH'(b);
    req_shift[i*SHIFT_W +: SHIFT_W] = SHIFT_W'(s);
  endtask

  // One clock: compare against model at negedge, then advance model past posedge.
  task automatic tick();
    int g;
    logic ca;
    logic [NREQ-1:0] exp_rdy;
    @(negedge clk);
    ca = !m_full || rsp_ready;
    g  = model_grant(req_valid, m_ptr);
    exp_rdy = '0;
    if (!rst && ca && g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("rsp_valid", 32'(rsp_valid), 32'(m_full));
    if (m_full) begin
      check("rsp_bits", 32'(rsp_bits), m_bits);
      check("rsp_id", 32'(rsp_id), 32'(m_id));
    end
    @(posedge clk);
    g_last = -1;
    if (rst) begin
      m_full = 1'b0; m_bits = 0; m_id = 0; m_ptr = 0;
    end else if (ca && g >= 0) begin
      m_full = 1'b1;
      m_bits = model_shift(32'(req_bits[g*WIDTH +: WIDTH]), 32'(req_shift[g*SHIFT_W +: SHIFT_W]));
      m_id   = g;
      m_ptr  = (g + 1) % NREQ;
      g_last = g;
    end else if (m_full && rsp_ready) begin
      m_full = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_bits = '0; req_shift = '0; rsp_ready = 1'b0;
    v4 = '0; b4 = '0; s4 = '0; rr4 = 1'b1;
    m_full = 1'b0; m_bits = 0; m_id = 0; m_ptr = 0; g_last = -1; pend = '0;
    @(posedge clk); #1;
    do_reset();
    check("reset_valid", 32'(rsp_valid), 32'd0);
    check("reset_bits", 32'(rsp_bits), 32'd0);
    check("reset_id", 32'(rsp_id), 32'd0);

    // Single request, no contention.
    set_req(0, 'h81, 1); req_valid = 4'b0001; rsp_ready = 1'b1;
    #1 check("single_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    check("single_bits", 32'(rsp_bits), 32'h02);
    check("single_id", 32'(rsp_id), 32'd0);
    check("single_valid", 32'(rsp_valid), 32'd1);

    // Round-robin under full load.
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 'h10 + i, 0);
    req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rr_id", 32'(rsp_id), 32'(k % 4));
      check("rr_bits", 32'(rsp_bits), 32'h10 + 32'(k % 4));
      check("rr_valid", 32'(rsp_valid), 32'd1);
    end

    // Backpressure: FULL id0, ptr=1, requests 1 and 2 waiting.
    req_valid = 4'b0110; rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 check("bp_ready", 32'(req_ready), 32'd0);
      tick();
      check("bp_id", 32'(rsp_id), 32'd0);
      check("bp_bits", 32'(rsp_bits), 32'h10);
    end
    rsp_ready = 1'b1;
    #1 check("bp_release", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    tick();

    // Shift boundaries on both widths.
    do_reset();
    set_req(0, 'hFF, 0); req_valid = 4'b0001; rsp_ready = 1'b1;
    v4 = 2'b01; b4 = 8'h0F; s4 = 6'd5;
    tick();
    check("shift0", 32'(rsp_bits), 32'hFF);
    check("w4_shift5", 32'(rb4), 32'd0);
    check("w4_valid", 32'(rv4), 32'd1);
    set_req(0, 'hFF, 7); s4 = 6'd3;
    tick();
    check("shift7", 32'(rsp_bits), 32'h80);
    check("w4_shift3", 32'(rb4), 32'h8);
    req_valid = '0; v4 = '0;
    tick();

    // Reset mid-operation with ptr=2.
    do_reset();
    set_req(1, 'h33, 2); req_valid = 4'b0010; rsp_ready = 1'b0;
    tick();
    check("mid_full", 32'(rsp_valid), 32'd1);
    rst = 1'b1; req_valid = '0;
    tick();
    rst = 1'b0;
    check("mid_valid", 32'(rsp_valid), 32'd0);
    check("mid_bits", 32'(rsp_bits), 32'd0);
    check("mid_id", 32'(rsp_id), 32'd0);
    req_valid = 4'b1111; rsp_ready = 1'b1;
    #1 check("mid_first", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    tick();

    // Simultaneous drain and fill with pointer wrap.
    do_reset();
    set_req(2, 'h05, 1); set_req(3, 'h07, 4);
    req_valid = 4'b0100; rsp_ready = 1'b1;
    tick();
    req_valid = 4'b1000;
    tick();
    check("df_valid", 32'(rsp_valid), 32'd1);
    check("df_id", 32'(rsp_id), 32'd3);
    check("df_bits", 32'(rsp_bits), 32'h70);
    req_valid = 4'b1111;
    #1 check("df_wrap", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    tick();

    // Randomized traffic; requesters hold until accepted.
    pend = '0;
    for (int c = 0; c < 600; c++) begin
      if (g_last >= 0) pend[g_last] = 1'b0;
      for (int i = 0; i < int'(NREQ); i++) begin
        if (!pend[i] && $urandom_range(1, 0) == 1) begin
          pend[i] = 1'b1;
          set_req(i, $urandom_range(255, 0), $urandom_range(7, 0));
        end
      end
      req_valid = pend;
      rsp_ready = ($urandom_range(3, 0) != 0);
      rst       = ($urandom_range(63, 0) == 0);
      tick();
      rst = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
